fetch_unit: RTL and testbench

Upstream neighbour of the CPU control FSM. It holds the program counter, reads 1–3 instruction bytes from program memory through a one-cycle-latency synchronous read port, and assembles them into an instruction register. When the instruction is complete it emits a one-cycle `fetch_complete` pulse. It then idles until control issues the next `fetch_operation`.

---
 rtl/cpu_common.sv | 11 +
 rtl/fetch_unit.sv | 108 ++++++++++
 tb/tb_fetch_unit.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/cpu_common.sv
// cpu_common: shared CPU command types
// Defines the fetch command encoding used between control and the fetch unit.
package cpu_common;

    typedef enum logic [1:0] {
        FETCH_NOP     = 2'd0,
        FETCH_INC_PC  = 2'd1,
        FETCH_LOAD_PC = 2'd2
    } fetch_operation_t;

endpackage

// File: rtl/fetch_unit.sv
// fetch_unit: program counter plus 1-3 byte instruction fetch from a 1-cycle-latency memory
// Ports:
//   i_clk, i_rst_n_async        clock (rising edge), asynchronous active-low reset
//   i_fetch_operation, i_new_pc command from control, jump target for FETCH_LOAD_PC
//   o_mem_addr, i_mem_rd_data   synchronous program memory read port (data one cycle later)
//   o_pc, o_inst, o_inst_len    address, assembled bytes and length of the current instruction
//   o_fetch_complete            one-cycle pulse when the instruction is assembled
//   o_fetch_idle                high while waiting for the next operation
module fetch_unit
    import cpu_common::*;
#(
    parameter int                    ADDR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n_async,
    input  fetch_operation_t      i_fetch_operation,
    input  logic [ADDR_WIDTH-1:0] i_new_pc,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    input  logic [7:0]            i_mem_rd_data,
    output logic [ADDR_WIDTH-1:0] o_pc,
    output logic [23:0]           o_inst,
    output logic [1:0]            o_inst_len,
    output logic                  o_fetch_complete,
    output logic                  o_fetch_idle
);

    typedef enum logic [2:0] {ADDR0, DATA0, DATA1, DATA2, IDLE} state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic [23:0]           r_inst;
    logic [1:0]            r_inst_len;
    logic                  r_fetch_complete;
    logic [ADDR_WIDTH-1:0] w_pc1;
    logic [ADDR_WIDTH-1:0] w_pc2;
    logic [ADDR_WIDTH-1:0] w_mem_addr;
    logic [1:0]            w_len0;
    logic                  w_done;

    assign w_pc1  = r_pc + ADDR_WIDTH'(1);
    assign w_pc2  = r_pc + ADDR_WIDTH'(2);
    // Length comes from the opcode byte as it arrives, so DATA0 can finish a 1-byte fetch.
    assign w_len0 = i_mem_rd_data[7] ? 2'd3 : i_mem_rd_data[6] ? 2'd2 : 2'd1;

    always_comb begin
        w_next_state = r_state;
        w_mem_addr   = r_pc;
        w_done       = 1'b0;
        case (r_state)
            ADDR0: w_next_state = DATA0;
            DATA0: begin
                w_mem_addr   = w_pc1;
                w_done       = (w_len0 == 2'd1);
                w_next_state = w_done ? IDLE : DATA1;
            end
            DATA1: begin
                w_mem_addr   = w_pc2;
                w_done       = (r_inst_len == 2'd2);
                w_next_state = w_done ? IDLE : DATA2;
            end
            DATA2: begin
                w_mem_addr   = w_pc2;
                w_done       = 1'b1;
                w_next_state = IDLE;
            end
            IDLE:    w_next_state = (i_fetch_operation != FETCH_NOP) ? ADDR0 : IDLE;
            default: w_next_state = ADDR0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n_async) begin
        if (!i_rst_n_async) begin
            r_state          <= ADDR0;
            r_pc             <= RESET_PC;
            r_inst           <= '0;
            r_inst_len       <= 2'd1;
            r_fetch_complete <= 1'b0;
        end else begin
            r_state          <= w_next_state;
            r_fetch_complete <= w_done;
            case (r_state)
                DATA0: begin
                    r_inst     <= {16'h0000, i_mem_rd_data};
                    r_inst_len <= w_len0;
                end
                DATA1: r_inst[15:8]  <= i_mem_rd_data;
                DATA2: r_inst[23:16] <= i_mem_rd_data;
                IDLE: begin
                    if (i_fetch_operation == FETCH_INC_PC)
                        r_pc <= r_pc + ADDR_WIDTH'(r_inst_len);
                    else if (i_fetch_operation == FETCH_LOAD_PC)
                        r_pc <= i_new_pc;
                end
                default: ;
            endcase
        end
    end

    assign o_mem_addr       = w_mem_addr;
    assign o_pc             = r_pc;
    assign o_inst           = r_inst;
    assign o_inst_len       = r_inst_len;
    assign o_fetch_complete = r_fetch_complete;
    assign o_fetch_idle     = (r_state == IDLE);

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and randomized checks of fetch_unit against an instruction-level model
module tb_fetch_unit;
    import cpu_common::*;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    fetch_operation_t op = FETCH_NOP;
    logic [15:0]      new_pc = '0;
    logic [15:0]      mem_addr;
    logic [7:0]       mem_rd_data = '0;
    logic [15:0]      pc;
    logic [23:0]      inst;
    logic [1:0]       inst_len;
    logic             fetch_complete;
    logic             fetch_idle;

    logic [7:0]  mem [65536];
    logic [15:0] m_pc;
    logic [1:0]  m_len;
    int          errors = 0;
    int          checks = 0;

    fetch_unit #(.ADDR_WIDTH(16), .RESET_PC(16'h0000)) dut (
        .i_clk            (clk),
        .i_rst_n_async    (rst_n),
        .i_fetch_operation(op),
        .i_new_pc         (new_pc),
        .o_mem_addr       (mem_addr),
        .i_mem_rd_data    (mem_rd_data),
        .o_pc             (pc),
        .o_inst           (inst),
        .o_inst_len       (inst_len),
        .o_fetch_complete (fetch_complete),
        .o_fetch_idle     (fetch_idle)
    );

    always #5 clk = ~clk;

    always @(posedge clk) mem_rd_data <= mem[mem_addr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Follows one fetch from cycle 1 (ADDR0) to completion; optionally drives a
    // FETCH_LOAD_PC while busy in cycle `inject`, which must have no effect.
    task automatic fetch(input int inject);
        logic [15:0] p, p1, p2;
        logic [7:0]  b0;
        logic [1:0]  len;
        logic [23:0] exp_inst;
        int          n;
        p  = m_pc;
        p1 = p + 16'd1;
        p2 = p + 16'd2;
        b0 = mem[p];
        len = (b0[7:6] == 2'b00) ? 2'd1 : (b0[7:6] == 2'b01) ? 2'd2 : 2'd3;
        exp_inst = {(len == 2'd3) ? mem[p2] : 8'h00, (len >= 2'd2) ? mem[p1] : 8'h00, b0};
        n = 1;
        check("pc_addr0", pc, p);
        check("mem_addr_addr0", mem_addr, p);
        check("idle_busy", fetch_idle, 0);
        while (!fetch_complete && n < 10) begin
            if (n == inject) begin
                op = FETCH_LOAD_PC;
                new_pc = 16'h5555;
            end
            step();
            op = FETCH_NOP;
            n++;
            if (n == 2) check("mem_addr_data0", mem_addr, p1);
            if (n == 3 && !fetch_complete) check("mem_addr_data1", mem_addr, p2);
        end
        check("latency", n, 32'(2 + len));
        check("inst", inst, exp_inst);
        check("inst_len", inst_len, len);
        check("pc_done", pc, p);
        check("idle_done", fetch_idle, 1);
        m_len = len;
        step();
        check("complete_pulse", fetch_complete, 0);
        check("idle_hold", fetch_idle, 1);
    endtask

    task automatic issue(input fetch_operation_t o, input logic [15:0] target);
        op = o;
        new_pc = target;
        step();
        op = FETCH_NOP;
        m_pc = (o == FETCH_INC_PC) ? m_pc + 16'(m_len) : target;
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        mem[0] = 8'h05; mem[1] = 8'h41; mem[2] = 8'hAB;
        mem[3] = 8'h80; mem[4] = 8'h12; mem[5] = 8'h34;
        step();
        step();
        check("rst_pc", pc, 0);
        check("rst_inst", inst, 0);
        check("rst_len", inst_len, 1);
        check("rst_complete", fetch_complete, 0);
        check("rst_idle", fetch_idle, 0);
        check("rst_mem_addr", mem_addr, 0);
        rst_n = 1'b1;
        m_pc = 16'h0000;
        fetch(0);
        issue(FETCH_INC_PC, 16'h0);
        check("inc_pc_1", pc, 16'h0001);
        fetch(0);
        issue(FETCH_INC_PC, 16'h0);
        check("inc_pc_3", pc, 16'h0003);
        fetch(0);
        issue(FETCH_INC_PC, 16'h0);
        check("inc_pc_6", pc, 16'h0006);
        fetch(0);
        issue(FETCH_LOAD_PC, 16'h1234);
        check("load_pc", pc, 16'h1234);
        check("load_mem_addr", mem_addr, 16'h1234);
        fetch(0);
        mem[16'hFFFF] = 8'hC0; mem[0] = 8'h11; mem[1] = 8'h22;
        issue(FETCH_LOAD_PC, 16'hFFFF);
        fetch(0);
        check("wrap_inst", inst, 24'h2211C0);
        issue(FETCH_INC_PC, 16'h0);
        check("wrap_pc", pc, 16'h0002);
        fetch(3);
        check("busy_load_ignored", pc, 16'h0002);
        issue(FETCH_LOAD_PC, 16'h0003);
        step();
        step();
        rst_n = 1'b0;
        #1;
        check("midrst_pc", pc, 0);
        check("midrst_inst", inst, 0);
        check("midrst_len", inst_len, 1);
        check("midrst_complete", fetch_complete, 0);
        check("midrst_idle", fetch_idle, 0);
        step();
        step();
        check("midrst_hold_complete", fetch_complete, 0);
        rst_n = 1'b1;
        m_pc = 16'h0000;
        m_len = 2'd1;
        fetch(0);
        check("restart_inst", inst, 24'h000011);
        for (int k = 0; k < 40; k++) begin
            repeat ($urandom_range(0, 2)) begin
                step();
                check("nop_idle", fetch_idle, 1);
                check("nop_complete", fetch_complete, 0);
            end
            if ($urandom_range(0, 1) == 0) issue(FETCH_INC_PC, 16'h0);
            else issue(FETCH_LOAD_PC, 16'($urandom));
            fetch(($urandom_range(0, 3) == 0) ? 2 : 0);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
